uart_response_encoder: RTL and testbench

- Converts one wishbone_master response (status, address, data, plus optional extra read words) into an ASCII-hex byte stream for the UART transmitter.
- Sits between the wishbone_master out_* response port and the UART TX byte interface.
- It is the transmit-side counterpart of the UART input handler that parses ASCII-hex commands into command/address/data.

---
 rtl/uart_response_encoder.sv | 161 ++++++++++++++++
 tb/tb_uart_response_encoder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_response_encoder.sv
// Turns one wishbone_master response (status, address, data and any extra
// data words) into an ASCII-hex byte stream for the UART transmitter.
// Frame: PREFIX, 8 status digits, SEP, 8 address digits, SEP, 8 data digits,
// then either TERMINATOR or, per extra word, SEP and 8 more data digits.
// The byte output port is named tx_byte because "byte" is a reserved word.
module uart_response_encoder #(
   parameter bit         LOWERCASE  = 1'b0,
   parameter logic [7:0] SEPARATOR  = 8'h20,
   parameter logic [7:0] TERMINATOR = 8'h0A,
   parameter logic [7:0] PREFIX     = 8'h53
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        out_en,
   input  logic [31:0] out_status,
   input  logic [31:0] out_address,
   input  logic [31:0] out_data,
   input  logic [27:0] out_data_count,
   output logic        out_ready,
   input  logic        uart_ready,
   output logic        uart_byte_en,
   output logic [7:0]  tx_byte,
   output logic        finished
);

   typedef enum logic [1:0] {StIdle, StSend, StGap, StWaitData} state_e;

   // Character index within the frame; extra words restart at IdxSepData.
   localparam logic [4:0] IdxSepAddr  = 5'd9;
   localparam logic [4:0] IdxSepData  = 5'd18;
   localparam logic [4:0] IdxLastStat = 5'd8;
   localparam logic [4:0] IdxLastAddr = 5'd17;
   localparam logic [4:0] IdxLastData = 5'd26;
   localparam logic [4:0] IdxEnd      = 5'd27;

   state_e      state_q, state_d;
   logic [31:0] status_q, address_q, data_q;
   logic [27:0] remaining_q;
   logic [4:0]  idx_q;
   logic [7:0]  byte_q;

   logic        load_first, load_word;
   logic [7:0]  cur_char;
   logic [31:0] word;
   logic [4:0]  off;
   logic        is_end;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      if (n < 4'd10) return 8'h30 + {4'h0, n};
      return (LOWERCASE ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
   endfunction

   // Decode the character at the current frame index; off counts nibbles from the LSN.
   always_comb begin
      cur_char = PREFIX;
      word     = status_q;
      off      = 5'd0;
      is_end   = (idx_q == IdxEnd);
      if (idx_q == 5'd0) begin
         cur_char = PREFIX;
      end else if (idx_q <= IdxLastStat) begin
         word     = status_q;
         off      = IdxLastStat - idx_q;
         cur_char = hex_char(word[{off[2:0], 2'b00} +: 4]);
      end else if (idx_q == IdxSepAddr) begin
         cur_char = SEPARATOR;
      end else if (idx_q <= IdxLastAddr) begin
         word     = address_q;
         off      = IdxLastAddr - idx_q;
         cur_char = hex_char(word[{off[2:0], 2'b00} +: 4]);
      end else if (idx_q == IdxSepData) begin
         cur_char = SEPARATOR;
      end else if (idx_q <= IdxLastData) begin
         word     = data_q;
         off      = IdxLastData - idx_q;
         cur_char = hex_char(word[{off[2:0], 2'b00} +: 4]);
      end else begin
         cur_char = TERMINATOR;
      end
   end

   // Next-state and handshake outputs; the byte strobe is combinational on uart_ready.
   always_comb begin
      state_d      = state_q;
      out_ready    = 1'b0;
      uart_byte_en = 1'b0;
      finished     = 1'b0;
      load_first   = 1'b0;
      load_word    = 1'b0;
      case (state_q)
         StIdle: begin
            out_ready = 1'b1;
            if (out_en) begin
               load_first = 1'b1;
               state_d    = StSend;
            end
         end
         StSend: begin
            if (is_end && (remaining_q != 28'd0)) begin
               state_d = StWaitData;
            end else if (uart_ready) begin
               uart_byte_en = 1'b1;
               if (is_end) begin
                  finished = 1'b1;
                  state_d  = StIdle;
               end else begin
                  state_d = StGap;
               end
            end
         end
         StGap: begin
            state_d = StSend;
         end
         StWaitData: begin
            out_ready = 1'b1;
            if (out_en) begin
               load_word = 1'b1;
               state_d   = StSend;
            end
         end
         default: state_d = StIdle;
      endcase
      tx_byte = uart_byte_en ? cur_char : byte_q;
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= StIdle;
      else      state_q <= state_d;
   end

   // Captured response fields, remaining word count, frame index and last byte sent.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         status_q    <= 32'd0;
         address_q   <= 32'd0;
         data_q      <= 32'd0;
         remaining_q <= 28'd0;
         idx_q       <= 5'd0;
         byte_q      <= 8'h00;
      end else begin
         if (load_first) begin
            status_q    <= out_status;
            address_q   <= out_address;
            data_q      <= out_data;
            remaining_q <= out_data_count;
            idx_q       <= 5'd0;
         end
         if (load_word) begin
            data_q      <= out_data;
            remaining_q <= remaining_q - 28'd1;
            idx_q       <= IdxSepData;
         end
         if (uart_byte_en) begin
            byte_q <= cur_char;
            idx_q  <= idx_q + 5'd1;
         end
      end
   end

endmodule

// File: tb/tb_uart_response_encoder.sv
// Self-checking bench: an upper-case and a lower-case encoder share stimulus;
// byte streams are collected and compared with literal vectors and a
// string-formatting reference model.
module tb_uart_response_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        out_en = 1'b0;
   logic [31:0] out_status = '0, out_address = '0, out_data = '0;
   logic [27:0] out_data_count = '0;
   logic        uart_ready = 1'b1;
   logic        rdy_a[2], en_a[2], fin_a[2];
   logic [7:0]  byte_a[2];

   int          checks = 0, errors = 0;
   string       s[2];
   int          fin_cnt[2];
   logic [7:0]  last[2];
   logic        prev_en[2];
   int          rdy_mode = 0;
   int          phase = 0;

   always #5 clk = ~clk;

   uart_response_encoder #(.LOWERCASE(1'b0)) u_upper (
      .clk(clk), .rst(rst), .out_en(out_en), .out_status(out_status),
      .out_address(out_address), .out_data(out_data), .out_data_count(out_data_count),
      .out_ready(rdy_a[0]), .uart_ready(uart_ready), .uart_byte_en(en_a[0]),
      .tx_byte(byte_a[0]), .finished(fin_a[0]));

   uart_response_encoder #(.LOWERCASE(1'b1)) u_lower (
      .clk(clk), .rst(rst), .out_en(out_en), .out_status(out_status),
      .out_address(out_address), .out_data(out_data), .out_data_count(out_data_count),
      .out_ready(rdy_a[1]), .uart_ready(uart_ready), .uart_byte_en(en_a[1]),
      .tx_byte(byte_a[1]), .finished(fin_a[1]));

   task automatic check(input string name, input logic ok, input string act, input string req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %s, expected %s", name, act, req);
      end
   endtask

   function automatic string vis(input string x);
      string r = "";
      for (int i = 0; i < x.len(); i++)
         r = (x[i] == 8'h0A) ? {r, "\\n"} : $sformatf("%s%c", r, x[i]);
      return r;
   endfunction

   // Reference: the whole response as text, built with hex formatting.
   function automatic string model(input logic [31:0] st, input logic [31:0] ad,
                                   input logic [31:0] d[$], input bit lc, input bit term);
      string body = $sformatf("%08h %08h %08h", st, ad, d[0]);
      for (int i = 1; i < d.size(); i++) body = {body, $sformatf(" %08h", d[i])};
      body = lc ? body.tolower() : body.toupper();
      return term ? {"S", body, "\n"} : {"S", body};
   endfunction

   // Collect strobed bytes; check hold, strobe gating, spacing and finished.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst) begin
            last[k] = 8'h00;
            prev_en[k] = 1'b0;
         end else begin
            if (en_a[k]) begin
               check("strobe_gating", uart_ready && !prev_en[k] && !rdy_a[k],
                     $sformatf("rdy=%0b prev_en=%0b out_ready=%0b", uart_ready, prev_en[k], rdy_a[k]),
                     "uart_ready=1 prev_en=0 out_ready=0");
               s[k] = $sformatf("%s%c", s[k], byte_a[k]);
               last[k] = byte_a[k];
            end else begin
               check("byte_hold", byte_a[k] == last[k], $sformatf("%02h", byte_a[k]),
                     $sformatf("%02h", last[k]));
            end
            check("finished_pulse", fin_a[k] == (en_a[k] && byte_a[k] == 8'h0A),
                  $sformatf("%0b", fin_a[k]), $sformatf("%0b", en_a[k] && byte_a[k] == 8'h0A));
            if (fin_a[k]) fin_cnt[k]++;
            prev_en[k] = en_a[k];
         end
      end
   end

   // uart_ready pattern: 0 = always ready, 1 = 3 low / 1 high, 2 = random.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: uart_ready = 1'b1;
            1: begin
               phase = (phase + 1) % 4;
               uart_ready = (phase == 0);
            end
            default: uart_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic wait_ready(input string name, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         #1;
         if (rdy_a[0] && rdy_a[1]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check(name, 1'b0, "timeout", "out_ready high");
   endtask

   task automatic run_resp(input logic [31:0] st, input logic [31:0] ad,
                           input logic [31:0] d[$], input logic [27:0] cnt,
                           input bit glitch, input bit wait_fin);
      bit ok, done;
      s[0] = ""; s[1] = "";
      fin_cnt[0] = 0; fin_cnt[1] = 0;
      wait_ready("ready_first", ok);
      if (!ok) return;
      out_status = st; out_address = ad; out_data = d[0]; out_data_count = cnt;
      out_en = 1'b1;
      @(negedge clk); #1;
      out_en = 1'b0;
      out_status = $urandom; out_address = $urandom; out_data = $urandom;
      out_data_count = 28'($urandom);
      if (glitch) begin
         repeat (5) @(negedge clk);
         #1;
         check("busy_not_ready", !rdy_a[0] && !rdy_a[1], $sformatf("%0b", rdy_a[0]), "0");
         out_data = 32'hFFFFFFFF; out_status = 32'hFFFFFFFF; out_data_count = '1;
         out_en = 1'b1;
         @(negedge clk); #1;
         out_en = 1'b0;
      end
      for (int i = 1; i < d.size(); i++) begin
         wait_ready("ready_word", ok);
         if (!ok) return;
         check("no_finish_between_words", fin_cnt[0] == 0, $sformatf("%0d", fin_cnt[0]), "0");
         out_data = d[i];
         out_en = 1'b1;
         @(negedge clk); #1;
         out_en = 1'b0;
         out_data = $urandom;
      end
      done = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         #1;
         if (wait_fin ? (fin_cnt[0] > 0 && fin_cnt[1] > 0) : (rdy_a[0] && rdy_a[1])) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) check("response_end", 1'b0, "timeout", "end of response");
      if (wait_fin) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic check_stream(input string name, input string e_up, input string e_lo);
      check({name, "_upper"}, s[0] == e_up, vis(s[0]), vis(e_up));
      check({name, "_lower"}, s[1] == e_lo, vis(s[1]), vis(e_lo));
      check({name, "_finished_once"}, fin_cnt[0] == 1 && fin_cnt[1] == 1,
            $sformatf("%0d/%0d", fin_cnt[0], fin_cnt[1]), "1/1");
      check({name, "_ready_back"}, rdy_a[0] && rdy_a[1], $sformatf("%0b", rdy_a[0]), "1");
   endtask

   typedef struct {
      logic [31:0] st;
      logic [31:0] ad;
      int          n;
      logic [31:0] d0, d1, d2;
      int          mode;
      string       e_up;
      string       e_lo;
   } vec_t;

   initial begin
      vec_t tbl[4];
      logic [31:0] d[$];
      logic [31:0] st, ad;
      string exp;
      bit ok;

      tbl[0] = '{32'h00000001, 32'h01000000, 1, 32'hDEADBEEF, 32'h0, 32'h0, 0,
                 "S00000001 01000000 DEADBEEF\n", "S00000001 01000000 deadbeef\n"};
      tbl[1] = '{32'h0000CAFE, 32'h00001000, 3, 32'h00000000, 32'h0000ABCD, 32'h12345678, 0,
                 "S0000CAFE 00001000 00000000 0000ABCD 12345678\n",
                 "S0000cafe 00001000 00000000 0000abcd 12345678\n"};
      tbl[2] = '{32'h00000001, 32'h01000000, 1, 32'hDEADBEEF, 32'h0, 32'h0, 1,
                 "S00000001 01000000 DEADBEEF\n", "S00000001 01000000 deadbeef\n"};
      tbl[3] = '{32'hFFFFFFFF, 32'h9ABCDEF0, 1, 32'hABCDEF01, 32'h0, 32'h0, 2,
                 "SFFFFFFFF 9ABCDEF0 ABCDEF01\n", "Sffffffff 9abcdef0 abcdef01\n"};

      repeat (3) @(negedge clk);
      #1;
      check("reset_out_ready", rdy_a[0] && rdy_a[1], $sformatf("%0b", rdy_a[0]), "1");
      check("reset_byte_en", !en_a[0] && !en_a[1], $sformatf("%0b", en_a[0]), "0");
      check("reset_byte", byte_a[0] == 8'h00 && byte_a[1] == 8'h00,
            $sformatf("%02h", byte_a[0]), "00");
      check("reset_finished", !fin_a[0] && !fin_a[1], $sformatf("%0b", fin_a[0]), "0");
      rst = 1'b1;

      // Literal vectors.
      for (int i = 0; i < 4; i++) begin
         rdy_mode = tbl[i].mode;
         d = {};
         d.push_back(tbl[i].d0);
         if (tbl[i].n > 1) d.push_back(tbl[i].d1);
         if (tbl[i].n > 2) d.push_back(tbl[i].d2);
         run_resp(tbl[i].st, tbl[i].ad, d, 28'(tbl[i].n - 1), 1'b0, 1'b1);
         check_stream($sformatf("vec%0d", i), tbl[i].e_up, tbl[i].e_lo);
      end

      // Strobe while busy must be ignored.
      rdy_mode = 1;
      d = {32'h11112222, 32'h33334444};
      run_resp(32'h5A5A0000, 32'h0000A5A5, d, 28'd1, 1'b1, 1'b1);
      check_stream("ignored_strobe", model(32'h5A5A0000, 32'h0000A5A5, d, 1'b0, 1'b1),
                   model(32'h5A5A0000, 32'h0000A5A5, d, 1'b1, 1'b1));

      // Maximum count: after two words the block still waits for more.
      rdy_mode = 0;
      d = {32'h01234567, 32'h89ABCDEF};
      run_resp(32'h00000002, 32'h00000003, d, 28'hFFFFFFF, 1'b0, 1'b0);
      exp = model(32'h00000002, 32'h00000003, d, 1'b0, 1'b0);
      check("maxcount_stream", s[0] == exp, vis(s[0]), vis(exp));
      check("maxcount_no_finish", fin_cnt[0] == 0, $sformatf("%0d", fin_cnt[0]), "0");
      check("maxcount_waiting", rdy_a[0], $sformatf("%0b", rdy_a[0]), "1");
      rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b1;

      // Reset after the 10th strobe aborts the frame.
      d = {32'hCCCCDDDD};
      s[0] = ""; s[1] = "";
      wait_ready("reset_test_ready", ok);
      out_status = 32'h76543210; out_address = 32'hFEDCBA98; out_data = d[0];
      out_data_count = 28'd0; out_en = 1'b1;
      @(negedge clk); #1;
      out_en = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (s[0].len() >= 10) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
         #1;
      end
      if (!ok) check("reset_test_progress", 1'b0, "timeout", "10 strobes");
      exp = model(32'h76543210, 32'hFEDCBA98, d, 1'b0, 1'b1);
      check("prefix_before_reset", s[0] == exp.substr(0, 9), vis(s[0]), vis(exp.substr(0, 9)));
      rst = 1'b0;
      #1;
      check("abort_byte_en", !en_a[0] && !en_a[1], $sformatf("%0b", en_a[0]), "0");
      check("abort_ready", rdy_a[0] && rdy_a[1], $sformatf("%0b", rdy_a[0]), "1");
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b1;
      d = {32'h0F0F0F0F};
      run_resp(32'h00000010, 32'h00000020, d, 28'd0, 1'b0, 1'b1);
      check_stream("after_reset", model(32'h10, 32'h20, d, 1'b0, 1'b1),
                   model(32'h10, 32'h20, d, 1'b1, 1'b1));

      // Randomized responses against the reference model.
      for (int t = 0; t < 12; t++) begin
         int n;
         rdy_mode = int'($urandom_range(0, 2));
         n = int'($urandom_range(1, 4));
         st = $urandom; ad = $urandom;
         d = {};
         for (int i = 0; i < n; i++) d.push_back($urandom);
         run_resp(st, ad, d, 28'(n - 1), 1'b0, 1'b1);
         check_stream($sformatf("rand%0d", t), model(st, ad, d, 1'b0, 1'b1),
                      model(st, ad, d, 1'b1, 1'b1));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
